// File: rtl/aurora_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aurora_pkg
// Purpose  : Shared definitions for the Aurora framing blocks: FSM state
//            encoding, header field offsets and a saturating counter helper.
// Revision : 1.0 - initial release
// ============================================================================
package aurora_pkg;

  // Receive framing states; HUNT searches for a header, PAYLOAD checks data.
  typedef enum logic [0:0] {
    ST_HUNT    = 1'b0,
    ST_PAYLOAD = 1'b1
  } frame_state_t;

  // Header field offsets, in the stream's MSB-first (bit 0 = MSB) numbering.
  localparam int c_hdr_mark_msb = 0;
  localparam int c_hdr_mark_lsb = 7;
  localparam int c_hdr_len_msb  = 8;
  localparam int c_hdr_len_lsb  = 15;

  // Width of the status counters.
  localparam int c_cnt_width = 16;

  // Increment a status counter, sticking at all-ones.
  function automatic logic [c_cnt_width-1:0] sat_inc(
    input logic [c_cnt_width-1:0] i_val,
    input logic                   i_en
  );
    if (i_en && (i_val != {c_cnt_width{1'b1}}))
      return i_val + c_cnt_width'(1);
    else
      return i_val;
  endfunction

endpackage : aurora_pkg
`default_nettype wire

// File: rtl/aurora_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : aurora_sync_fifo
// Purpose  : Single-clock first-word-fall-through FIFO. The head entry is
//            visible on o_rd_data whenever the FIFO is not empty; an empty
//            FIFO presents all-zero data. A write while full succeeds only
//            when a read frees a slot in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module aurora_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_aw = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [c_aw:0]      r_wr_ptr;
  logic [c_aw:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_wr;
  logic               w_rd;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

  // A read frees the head slot this cycle, so a write may reuse it when full.
  assign w_rd = i_rd_en && !o_empty;
  assign w_wr = i_wr_en && (!o_full || w_rd);

  // Head entry falls through; gated to zero so an empty FIFO shows no stale data.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

  // Storage array: written on accepted writes, never reset.
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wr_ptr[c_aw-1:0]] <= i_wr_data;
  end

  // Pointer update; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
      if (w_rd)
        r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
    end
  end

endmodule : aurora_sync_fifo
`default_nettype wire

// File: rtl/aurora_rx_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : aurora_rx_frame_checker
// Purpose  : Receives an Aurora streaming interface, locates framed headers
//            (marker byte + length), checks payload against an incrementing
//            reference sequence, forwards payload through an output FIFO
//            with a LAST tag, and keeps saturating status counters.
// Revision : 1.0 - initial release
// ============================================================================
module aurora_rx_frame_checker
  import aurora_pkg::*;
#(
  parameter int         DATA_WIDTH = 16,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] SOF_MARK   = 8'hA5
) (
  input  logic                  USER_CLK,
  input  logic                  RESET_N,
  input  logic                  CHANNEL_UP,
  input  logic [0:DATA_WIDTH-1] RX_D,
  input  logic                  RX_SRC_RDY_N,
  output logic [0:DATA_WIDTH-1] OUT_D,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  OUT_LAST,
  output logic [15:0]           FRAME_CNT,
  output logic [15:0]           HDR_ERR_CNT,
  output logic [15:0]           DATA_ERR_CNT,
  output logic [15:0]           OVF_CNT,
  output logic [15:0]           ABORT_CNT,
  output logic                  LOCKED
);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  frame_state_t          r_state;
  frame_state_t          w_state_nxt;
  logic [0:DATA_WIDTH-1] r_exp;        // expected next payload word
  logic [7:0]            r_remaining;  // payload words still to come
  logic                  r_frame_bad;  // current frame has seen a mismatch
  logic [15:0]           r_frame_cnt;
  logic [15:0]           r_hdr_err_cnt;
  logic [15:0]           r_data_err_cnt;
  logic [15:0]           r_ovf_cnt;
  logic [15:0]           r_abort_cnt;
  logic                  r_locked;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic                  w_acc;        // word accepted this cycle
  logic                  w_hdr_valid;  // accepted word looks like a good header
  logic                  w_hdr_ok;
  logic                  w_hdr_err;
  logic                  w_pay;        // accepted payload word
  logic                  w_abort;
  logic                  w_last;
  logic                  w_mismatch;
  logic                  w_ovf;
  logic                  w_good_last;
  logic                  w_err_evt;
  logic                  w_fifo_rd;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [DATA_WIDTH:0]   w_fifo_wdata;
  logic [DATA_WIDTH:0]   w_fifo_rdata;

  assign w_acc       = !RX_SRC_RDY_N && CHANNEL_UP;
  assign w_hdr_valid = (RX_D[c_hdr_mark_msb:c_hdr_mark_lsb] == SOF_MARK) &&
                       (RX_D[c_hdr_len_msb:c_hdr_len_lsb] != 8'd0);

  // LEN is never 0 inside PAYLOAD, so remaining==1 marks the final word.
  assign w_last      = w_pay && (r_remaining == 8'd1);
  assign w_mismatch  = w_pay && (RX_D != r_exp);

  // The output side is first-word-fall-through: VALID simply means not empty.
  assign w_fifo_rd   = !w_fifo_empty && OUT_READY;
  assign w_ovf       = w_pay && w_fifo_full && !w_fifo_rd;

  // A frame counts as good only if no word in it, including the last, mismatched.
  assign w_good_last = w_last && !r_frame_bad && !w_mismatch;

  // Any error in the same cycle as a good frame end wins over the lock.
  assign w_err_evt   = w_hdr_err || w_mismatch || w_ovf || w_abort;

  assign w_fifo_wdata = {w_last, RX_D};

  // State register.
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N)
      r_state <= ST_HUNT;
    else
      r_state <= w_state_nxt;
  end

  // Next-state and per-cycle event decode.
  always_comb begin
    w_state_nxt = r_state;
    w_hdr_ok    = 1'b0;
    w_hdr_err   = 1'b0;
    w_pay       = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      ST_HUNT: begin
        if (w_acc) begin
          if (w_hdr_valid) begin
            w_hdr_ok    = 1'b1;
            w_state_nxt = ST_PAYLOAD;
          end else begin
            w_hdr_err   = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        // Losing the channel mid-frame abandons the frame without a LAST word.
        if (!CHANNEL_UP) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_HUNT;
        end else if (w_acc) begin
          w_pay = 1'b1;
          if (r_remaining == 8'd1)
            w_state_nxt = ST_HUNT;
        end
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  // Payload tracking: expected value, remaining count and frame error flag.
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_exp       <= '0;
      r_remaining <= 8'd0;
      r_frame_bad <= 1'b0;
    end else begin
      if (w_hdr_ok) begin
        r_remaining <= RX_D[c_hdr_len_msb:c_hdr_len_lsb];
        r_frame_bad <= 1'b0;
      end else if (w_pay) begin
        r_remaining <= r_remaining - 8'd1;
        if (w_mismatch)
          r_frame_bad <= 1'b1;
      end
      // Expected value survives frame boundaries; a mismatch resyncs to the data.
      if (w_pay) begin
        if (w_mismatch)
          r_exp <= RX_D + DATA_WIDTH'(1);
        else
          r_exp <= r_exp + DATA_WIDTH'(1);
      end
    end
  end

  // Saturating status counters and the lock indicator.
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_frame_cnt    <= 16'd0;
      r_hdr_err_cnt  <= 16'd0;
      r_data_err_cnt <= 16'd0;
      r_ovf_cnt      <= 16'd0;
      r_abort_cnt    <= 16'd0;
      r_locked       <= 1'b0;
    end else begin
      r_frame_cnt    <= sat_inc(r_frame_cnt,    w_good_last);
      r_hdr_err_cnt  <= sat_inc(r_hdr_err_cnt,  w_hdr_err);
      r_data_err_cnt <= sat_inc(r_data_err_cnt, w_mismatch);
      r_ovf_cnt      <= sat_inc(r_ovf_cnt,      w_ovf);
      r_abort_cnt    <= sat_inc(r_abort_cnt,    w_abort);
      if (w_err_evt)
        r_locked <= 1'b0;
      else if (w_good_last)
        r_locked <= 1'b1;
    end
  end

  // Output buffer: payload plus LAST tag in the top bit.
  aurora_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (USER_CLK),
    .rst_n     (RESET_N),
    .i_wr_en   (w_pay),
    .i_wr_data (w_fifo_wdata),
    .i_rd_en   (OUT_READY),
    .o_rd_data (w_fifo_rdata),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  assign OUT_VALID    = !w_fifo_empty;
  assign OUT_D        = w_fifo_rdata[DATA_WIDTH-1:0];
  assign OUT_LAST     = w_fifo_rdata[DATA_WIDTH];
  assign FRAME_CNT    = r_frame_cnt;
  assign HDR_ERR_CNT  = r_hdr_err_cnt;
  assign DATA_ERR_CNT = r_data_err_cnt;
  assign OVF_CNT      = r_ovf_cnt;
  assign ABORT_CNT    = r_abort_cnt;
  assign LOCKED       = r_locked;

endmodule : aurora_rx_frame_checker
`default_nettype wire

// File: doc/aurora_rx_frame_checker.md
AURORA_RX_FRAME_CHECKER -- requirements
Module: aurora_rx_frame_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the Aurora stream width (16 x N_LANE), legal values 16, 32, 48 or 64.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning the output buffer depth in words; it is a power of 2 and at least 4.
REQ-003 SHALL have parameter SOF_MARK, default 8'hA5, meaning the header marker byte.
REQ-004 SHALL have port USER_CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port RESET_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port CHANNEL_UP, input, 1 bit: Aurora channel status.
REQ-007 SHALL have port RX_D, input, [0:DATA_WIDTH-1]: stream receive data; bit 0 is the MSB.
REQ-008 SHALL have port RX_SRC_RDY_N, input, 1 bit: active-low receive data valid; there is no backpressure.
REQ-009 SHALL have port OUT_D, output, [0:DATA_WIDTH-1]: payload word to the application.
REQ-010 SHALL have ports OUT_VALID (output, 1 bit), OUT_READY (input, 1 bit) and OUT_LAST (output, 1 bit): a valid/ready handshake, with OUT_LAST marking the final payload word of a frame.
REQ-011 SHALL have port FRAME_CNT, output, 16 bits: count of good frames.
REQ-012 SHALL have ports HDR_ERR_CNT, DATA_ERR_CNT, OVF_CNT and ABORT_CNT, each output, 16 bits: error counters.
REQ-013 SHALL have port LOCKED, output, 1 bit: high after a good frame, low after any error.

Function
REQ-014 SHALL accept an RX word only in a cycle where RX_SRC_RDY_N=0 and CHANNEL_UP=1; all other cycles are ignored.
REQ-015 SHALL define the header as RX_D[0:7]==SOF_MARK and LEN=RX_D[8:15], with LEN in 1..255; bits [16:DATA_WIDTH-1] are ignored.
REQ-016 SHALL implement an FSM with states HUNT (reset state) and PAYLOAD.
- HUNT, valid header: load remaining=LEN, go to PAYLOAD.
- HUNT, any other accepted word: HDR_ERR_CNT+1, stay in HUNT.
REQ-017 SHALL, in PAYLOAD, compare each accepted word with the expected value EXP (DATA_WIDTH bits).
- Match: EXP increments by 1, wrapping mod 2^DATA_WIDTH.
- Mismatch: DATA_ERR_CNT+1 and EXP := RX_D+1 (resync); the word is still forwarded.
REQ-018 SHALL decrement remaining on each accepted payload word.
- When remaining reaches 0: tag the word OUT_LAST=1 and return to HUNT.
- If that frame had no mismatch: FRAME_CNT+1, LOCKED:=1.
REQ-019 SHALL carry EXP across frame boundaries; EXP resets to 0 only on reset.
REQ-020 SHALL set LOCKED:=0 on any header error, data mismatch, overflow or abort.
REQ-021 SHALL write each accepted payload word into the FIFO the same cycle it is accepted.
- RX_D to OUT_VALID latency is 1 cycle when the FIFO is empty.
- Reading uses first-word-fall-through; a word transfers when OUT_VALID && OUT_READY.
REQ-022 SHALL, when the FIFO is full and no read occurs that cycle, drop the word and increment OVF_CNT.
- A simultaneous read and write when full SHALL succeed.
- FSM and EXP tracking are unaffected by a drop.
REQ-023 SHALL, if CHANNEL_UP falls while in PAYLOAD: ABORT_CNT+1, return to HUNT, emit no OUT_LAST, and keep words already in the FIFO.
REQ-024 SHALL make all counters saturate at 16'hFFFF.
REQ-025 SHALL hold OUT_D stable while OUT_VALID=1 and OUT_READY=0.

Reset
REQ-026 SHALL, on RESET_N=0 (asynchronous): FSM=HUNT, EXP=0, remaining=0, FIFO empty, OUT_VALID=0, OUT_LAST=0, OUT_D=0, all counters 0, LOCKED=0.
REQ-027 SHALL take reset release synchronously to USER_CLK; asserting reset mid-frame discards the FIFO contents and the partial frame.

Structure
REQ-028 SHALL place the FSM state encoding and the header field offsets (MARK 0:7, LEN 8:15) in the shared package aurora_pkg, for reuse by the TX frame generator.
REQ-029 SHALL use one sub-module, aurora_sync_fifo: width DATA_WIDTH+1 (the extra bit is LAST), depth FIFO_DEPTH, first-word-fall-through, with full and empty outputs.
REQ-030 SHALL instantiate no vendor primitives.

Verification
REQ-031 SHALL cover: header A5_03, then 0,1,2 with OUT_READY=1 -> OUT_D 0,1,2, OUT_LAST on 2, FRAME_CNT=1, LOCKED=1.
REQ-032 SHALL cover: header A5_02, then 3,7 -> DATA_ERR_CNT=1 (on 7), EXP=8, FRAME_CNT unchanged, LOCKED=0.
REQ-033 SHALL cover: words 1234, A5_00 in HUNT -> HDR_ERR_CNT=2, still in HUNT, no output.
REQ-034 SHALL cover: FIFO_DEPTH=4, OUT_READY=0, header A5_06 plus 6 words -> 4 buffered, OVF_CNT=2, OUT_LAST lost, then drain 4 words in order.
REQ-035 SHALL cover: CHANNEL_UP dropped after 2 of 5 payload words -> ABORT_CNT=1, HUNT, 2 words readable, neither with OUT_LAST.
REQ-036 SHALL cover: RESET_N pulsed low mid-frame asynchronously -> all outputs 0 within the same cycle; the next header is accepted with EXP=0.
